pe_nic: RTL and testbench

- Network interface between a processor and the router's PE port on the bidirectional ring.
- Drives the router's PE input side (send/ready/data) and sinks the router's PE output side.
- Exposes a one-entry input channel buffer and a one-entry output channel buffer to the processor through a 2-bit register address space.
- Honours the router's polarity phase, so each packet is injected only in its matching virtual-channel phase.

---
 rtl/pe_nic_pkg.sv | 11 +
 rtl/nic_chan_buf.sv | 28 ++
 rtl/pe_nic.sv | 90 +++++++++
 tb/tb_pe_nic.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pe_nic_pkg.sv
// pe_nic_pkg: register map and packet field positions shared by the NIC files.
package pe_nic_pkg;
    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;
    localparam int VC_BIT  = 63;
    localparam int DIR_BIT = 62;
    localparam int HOP_MSB = 55;
    localparam int HOP_LSB = 48;
endpackage

// File: rtl/nic_chan_buf.sv
// nic_chan_buf: one-entry channel buffer with full flag; load wins over clear.
module nic_chan_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic         o_full,
    output logic [W-1:0] o_q
);
    logic         r_full;
    logic [W-1:0] r_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full <= 1'b0;
            r_q    <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_q    <= i_d;
        end else if (i_clr) begin
            r_full <= 1'b0;
        end
    end
    assign o_full = r_full;
    assign o_q    = r_q;
endmodule

// File: rtl/pe_nic.sv
// pe_nic: processor network interface for the ring router PE port, one-entry buffer per direction.
// Defining NIC_DROP_CNT_EN adds a saturating dropped-write counter readable at the output status address.
module pe_nic #(
    parameter int DATA_W     = 64,
    parameter int VC_BIT     = pe_nic_pkg::VC_BIT,
    parameter int DROP_CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    input  logic              net_polarity,
    output logic              net_so,
    input  logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [DATA_W-1:0] net_di
);
    import pe_nic_pkg::*;

    logic                  w_rd, w_wr, w_wr_out;
    logic                  w_in_full, w_out_full;
    logic [DATA_W-1:0]     w_in_buf, w_out_buf, w_out_stat, w_rd_data;
    logic [DROP_CNT_W-1:0] w_drop_cnt;
    logic [DATA_W-1:0]     r_d_out;

    assign w_rd     = nicEn & ~nicWrEn;
    assign w_wr     = nicEn & nicWrEn;
    assign w_wr_out = w_wr & (addr == ADDR_OUT_BUF);

    // Inject only when the router phase matches the packet's virtual channel.
    assign net_so = w_out_full & net_ro & (net_polarity == w_out_buf[VC_BIT]);
    assign net_ri = ~w_in_full;
    assign net_do = w_out_buf;

    nic_chan_buf #(.W(DATA_W)) u_out_buf (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_wr_out & ~w_out_full),
        .i_clr  (net_so),
        .i_d    (d_in),
        .o_full (w_out_full),
        .o_q    (w_out_buf)
    );

    nic_chan_buf #(.W(DATA_W)) u_in_buf (
        .clk    (clk),
        .reset  (reset),
        .i_load (net_si & ~w_in_full),
        .i_clr  (w_rd & (addr == ADDR_IN_BUF) & w_in_full),
        .i_d    (net_di),
        .o_full (w_in_full),
        .o_q    (w_in_buf)
    );

`ifdef NIC_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_drop_cnt <= '0;
        else if (w_wr & (addr == ADDR_OUT_STAT))
            r_drop_cnt <= '0;
        else if (w_wr_out & w_out_full & ~&r_drop_cnt)
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end
    assign w_drop_cnt = r_drop_cnt;
`else
    assign w_drop_cnt = '0;
`endif

    assign w_out_stat = {{(DATA_W-1){1'b0}}, w_out_full} | (DATA_W'(w_drop_cnt) << 8);

    always_comb begin
        w_rd_data = (addr == ADDR_IN_BUF)  ? w_in_buf :
                    (addr == ADDR_IN_STAT) ? {{(DATA_W-1){1'b0}}, w_in_full} :
                    (addr == ADDR_OUT_BUF) ? w_out_buf : w_out_stat;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_d_out <= '0;
        else if (w_rd)
            r_d_out <= w_rd_data;
    end
    assign d_out = r_d_out;
endmodule

// File: tb/tb_pe_nic.sv
// tb_pe_nic: table-driven bench for pe_nic; read data is checked through a queue one cycle after the read.
module tb_pe_nic;
    logic        clk = 1'b0, reset = 1'b1;
    logic [1:0]  addr = '0;
    logic [63:0] d_in = '0, d_out, net_do, net_di = '0;
    logic        nicEn = 1'b0, nicWrEn = 1'b0, net_polarity = 1'b0;
    logic        net_so, net_ro = 1'b1, net_si = 1'b0, net_ri;

    pe_nic dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .net_polarity(net_polarity),
        .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_si(net_si), .net_ri(net_ri), .net_di(net_di)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en, we;
        logic [1:0]  a;
        logic [63:0] din;
        logic        si;
        logic [63:0] di;
        logic        ro, pol, so, ri, rd;
        logic [63:0] q;
    } vec_t;

    int          n_pass = 0, n_total = 0;
    logic [63:0] sb[$];
    logic [7:0]  drops = '0;
    vec_t        tbl[21];

    localparam logic [63:0] PK_AA = 64'h8000_0000_0000_00AA;

    function automatic vec_t mk(logic en, logic we, logic [1:0] a, logic [63:0] din,
                                logic si, logic [63:0] di, logic ro, logic pol,
                                logic so, logic ri, logic rd, logic [63:0] q);
        vec_t v;
        v.en = en; v.we = we; v.a = a; v.din = din; v.si = si; v.di = di;
        v.ro = ro; v.pol = pol; v.so = so; v.ri = ri; v.rd = rd; v.q = q;
        return v;
    endfunction

    function automatic logic [63:0] ostat(logic f);
`ifdef NIC_DROP_CNT_EN
        return {48'b0, drops, 7'b0, f};
`else
        return {63'b0, f};
`endif
    endfunction

    task automatic note_drop();
        if (drops != 8'hFF) drops = drops + 8'd1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step(input vec_t v, input string nm);
        logic [63:0] e;
        nicEn = v.en; nicWrEn = v.we; addr = v.a; d_in = v.din;
        net_si = v.si; net_di = v.di; net_ro = v.ro; net_polarity = v.pol;
        #1;
        check({nm, " net_so"}, {63'b0, net_so}, {63'b0, v.so});
        check({nm, " net_ri"}, {63'b0, net_ri}, {63'b0, v.ri});
        if (v.rd) sb.push_back(v.q);
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({nm, " d_out"}, d_out, e);
        end
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = mk(1,0,2'b01,0,           0,0,      1,0, 0,1, 1,64'h0);
        tbl[1]  = mk(1,0,2'b11,0,           0,0,      1,0, 0,1, 1,64'h0);
        tbl[2]  = mk(1,1,2'b10,PK_AA,       0,0,      1,0, 0,1, 0,0);
        tbl[3]  = mk(1,0,2'b11,0,           0,0,      1,0, 0,1, 1,64'h1);
        tbl[4]  = mk(0,0,2'b00,0,           0,0,      1,1, 1,1, 0,0);
        tbl[5]  = mk(1,0,2'b11,0,           0,0,      1,0, 0,1, 1,64'h0);
        tbl[6]  = mk(1,1,2'b10,64'h55,      0,0,      1,1, 0,1, 0,0);
        tbl[7]  = mk(1,0,2'b10,0,           0,0,      1,1, 0,1, 1,64'h55);
        tbl[8]  = mk(0,0,2'b00,0,           0,0,      0,0, 0,1, 0,0);
        tbl[9]  = mk(0,0,2'b00,0,           0,0,      1,0, 1,1, 0,0);
        tbl[10] = mk(0,0,2'b00,0,           1,64'h1234,1,0, 0,1, 0,0);
        tbl[11] = mk(1,0,2'b01,0,           0,0,      1,0, 0,0, 1,64'h1);
        tbl[12] = mk(1,0,2'b00,0,           1,64'h5678,1,0, 0,0, 1,64'h1234);
        tbl[13] = mk(1,0,2'b01,0,           1,64'h5678,1,0, 0,1, 1,64'h0);
        tbl[14] = mk(1,0,2'b00,0,           0,0,      1,0, 0,0, 1,64'h5678);
        tbl[15] = mk(1,0,2'b00,0,           0,0,      1,0, 0,1, 1,64'h5678);
        tbl[16] = mk(1,1,2'b00,64'hFFFF,    0,0,      1,0, 0,1, 0,0);
        tbl[17] = mk(1,0,2'b01,0,           0,0,      1,0, 0,1, 1,64'h0);
        tbl[18] = mk(1,1,2'b10,64'h8000_0000_0000_0001,0,0,1,0, 0,1, 0,0);
        tbl[19] = mk(1,1,2'b10,64'h8000_0000_0000_0002,0,0,1,1, 1,1, 0,0);
        tbl[20] = mk(1,0,2'b10,0,           0,0,      1,0, 0,1, 1,64'h8000_0000_0000_0001);

        #3;
        check("reset d_out", d_out, 64'h0);
        check("reset net_so", {63'b0, net_so}, 64'h0);
        check("reset net_ri", {63'b0, net_ri}, 64'h1);
        check("reset net_do", net_do, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            if (i == 19) note_drop();
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Back-pressure: the packet waits while the router is not ready; a second write is dropped.
        step(mk(1,1,2'b10,PK_AA,0,0,0,1, 0,1, 0,0), "bp write");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) note_drop();
            step(mk(i == 2,1,2'b10,64'h55,0,0,0,i[0], 0,1, 0,0), $sformatf("bp hold%0d", i));
        end
        check("bp net_do", net_do, PK_AA);
        step(mk(0,0,2'b00,0,0,0,1,0, 0,1, 0,0), "bp wrong phase");
        step(mk(0,0,2'b00,0,0,0,1,1, 1,1, 0,0), "bp send");
        step(mk(1,0,2'b11,0,0,0,1,0, 0,1, 1,ostat(1'b0)), "bp stat");
        step(mk(1,0,2'b10,0,0,0,1,0, 0,1, 1,PK_AA), "bp readback");

`ifdef NIC_DROP_CNT_EN
        drops = '0;
        step(mk(1,1,2'b11,0,0,0,1,0, 0,1, 0,0), "cnt clear");
        step(mk(1,0,2'b11,0,0,0,1,0, 0,1, 1,ostat(1'b0)), "cnt zero");
        step(mk(1,1,2'b10,64'h1,0,0,0,0, 0,1, 0,0), "cnt fill");
        for (int i = 0; i < 3; i++) begin
            note_drop();
            step(mk(1,1,2'b10,64'h2,0,0,0,0, 0,1, 0,0), $sformatf("cnt drop%0d", i));
        end
        step(mk(1,0,2'b11,0,0,0,0,0, 0,1, 1,64'h301), "cnt three");
        for (int i = 0; i < 260; i++) begin
            note_drop();
            step(mk(1,1,2'b10,64'h2,0,0,0,0, 0,1, 0,0), "cnt sat");
        end
        step(mk(1,0,2'b11,0,0,0,0,0, 0,1, 1,64'hFF01), "cnt saturated");
        drops = '0;
        step(mk(1,1,2'b11,0,0,0,0,0, 0,1, 0,0), "cnt clear2");
        step(mk(1,0,2'b11,0,0,0,0,0, 0,1, 1,64'h1), "cnt cleared");
        step(mk(1,0,2'b10,0,0,0,1,0, 1,1, 1,64'h1), "cnt drain");
`endif

        // Asynchronous reset in the middle of a cycle with both buffers full.
        step(mk(1,1,2'b10,PK_AA,1,64'h99,0,1, 0,1, 0,0), "rst fill");
        step(mk(1,0,2'b10,0,0,0,0,1, 0,0, 1,PK_AA), "rst read");
        nicEn = 1'b0; net_ro = 1'b1; net_polarity = 1'b1;
        #1;
        check("pre-rst net_so", {63'b0, net_so}, 64'h1);
        #2;
        reset = 1'b1;
        drops = '0;
        #1;
        check("rst net_so", {63'b0, net_so}, 64'h0);
        check("rst net_ri", {63'b0, net_ri}, 64'h1);
        check("rst d_out", d_out, 64'h0);
        check("rst net_do", net_do, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        step(mk(1,0,2'b01,0,0,0,1,1, 0,1, 1,64'h0), "rst in stat");
        step(mk(1,0,2'b11,0,0,0,1,1, 0,1, 1,64'h0), "rst out stat");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
